// File: rtl/fifo_rd_stream_if.sv
// Valid/ready output stream carrying drained FIFO nibbles to the datapath.
// The master drives data and valid; the slave drives ready.
interface fifo_rd_stream_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] OutData;
  logic             OutValid;
  logic             OutReady;

  modport master (output OutData, output OutValid, input OutReady);
  modport slave  (input OutData, input OutValid, output OutReady);
endinterface

// File: rtl/fifo_rd_stream.sv
// FIFO drain into a valid/ready stream through a 2-entry skid buffer, with parity check and word counter.
// Latency: RdReq in cycle N gives OutValid in N+2; backpressure: reads stop once buffered + in-flight reaches 2.
module fifo_rd_stream #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 16
) (
  input  logic             Clock,
  input  logic             Aclr_n,
  input  logic             Enable,
  input  logic             Empty,
  input  logic [WIDTH-1:0] Q,
  input  logic             EDO,
  output logic             RdReq,
  input  logic             ErrClr,
  output logic             ParErr,
  output logic [CNTW-1:0]  WordCnt,
  fifo_rd_stream_if.master out_stream
);

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic [1:0]       occ;
  logic             inflight;
  logic             head;
  logic [WIDTH-1:0] entry [2];

  logic             pop;
  logic             wr_idx;
  logic             par_bad;
  logic [2:0]       credit_sum;

  assign pop        = out_stream.OutValid & out_stream.OutReady;
  assign credit_sum = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign RdReq      = Aclr_n & Enable & ~Empty & (credit_sum < 3'd2);

  // Tail is head + occ; with occ == 2 and a pop this lands on the slot being freed.
  assign wr_idx  = head ^ occ[0];
  assign par_bad = inflight & (EDO != (^Q));

  assign out_stream.OutValid = (occ != 2'd0);
  assign out_stream.OutData  = entry[head];

  // Parity is judged at capture time, so only the data nibble needs to be buffered.
  always_ff @(posedge Clock or negedge Aclr_n) begin
    if (!Aclr_n) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      head     <= 1'b0;
      entry[0] <= '0;
      entry[1] <= '0;
      ParErr   <= 1'b0;
      WordCnt  <= '0;
    end else begin
      inflight <= RdReq;
      if (inflight) begin
        entry[wr_idx] <= Q;
      end
      if (pop) begin
        head    <= ~head;
        WordCnt <= WordCnt + CNT_ONE;
      end
      case ({inflight, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
      if (par_bad) begin
        ParErr <= 1'b1;
      end else if (ErrClr) begin
        ParErr <= 1'b0;
      end
    end
  end

  // The credit rule must make a capture into a full buffer without a pop impossible.
  assert property (@(posedge Clock) disable iff (!Aclr_n)
                   !(inflight && (occ == 2'd2) && !pop));

endmodule
